mmio_timer: RTL and testbench

Memory-mapped timer/output peripheral that acts as the responder on the processor's data-memory port. It decodes the same `MemWrite`/`DataAdr`/`WriteData`/`ReadData` signals the core drives toward data memory. It answers a 32-byte address window with a free-running counter, a compare/match flag with interrupt, and a 32-bit general-purpose output register. The system top muxes `ReadData` between data memory and this block using `Hit`.

---
 rtl/mmio_timer.sv | 101 ++++++++++
 tb/tb_mmio_timer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// Memory-mapped timer/GPIO responder on the core's data-memory port.
// Free-running counter with compare/match flag, interrupt and a 32-bit output register.
module mmio_timer #(
  parameter logic [31:0] BASE = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        Irq,
  output logic [31:0] GpioOut
);

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_COUNT  = 3'd1;
  localparam logic [2:0] IDX_CMP    = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_OUT    = 3'd4;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        flag_q, flag_d;
  logic [31:0] out_q, out_d;

  logic [2:0]  idx;
  logic        we;
  logic        en, reload, irq_en;
  logic        match;
  logic        unused_adr;

  assign unused_adr = ^DataAdr[1:0];

  assign Hit = (DataAdr[31:5] == BASE[31:5]);
  assign idx = DataAdr[4:2];
  assign we  = MemWrite & Hit;

  assign en     = ctrl_q[0];
  assign reload = ctrl_q[1];
  assign irq_en = ctrl_q[2];

  // Match uses the registered CTRL/COMPARE, so same-edge writes only affect later cycles.
  assign match = en && (count_q == cmp_q);

  always_comb begin
    ctrl_d  = ctrl_q;
    cmp_d   = cmp_q;
    out_d   = out_q;
    count_d = count_q;
    flag_d  = flag_q;

    if (we && idx == IDX_CTRL) ctrl_d = WriteData[2:0];
    if (we && idx == IDX_CMP)  cmp_d  = WriteData;
    if (we && idx == IDX_OUT)  out_d  = WriteData;

    if (we && idx == IDX_COUNT)  count_d = WriteData;
    else if (match && reload)    count_d = 32'd0;
    else if (en)                 count_d = count_q + 32'd1;

    // A new match wins over a coincident write-1-to-clear.
    if (match)                                          flag_d = 1'b1;
    else if (we && idx == IDX_STATUS && WriteData[0])   flag_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= 3'd0;
      count_q <= 32'd0;
      cmp_q   <= 32'd0;
      flag_q  <= 1'b0;
      out_q   <= 32'd0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    ReadData = 32'd0;
    if (Hit) begin
      case (idx)
        IDX_CTRL:   ReadData = {29'd0, ctrl_q};
        IDX_COUNT:  ReadData = count_q;
        IDX_CMP:    ReadData = cmp_q;
        IDX_STATUS: ReadData = {31'd0, flag_q};
        IDX_OUT:    ReadData = out_q;
        default:    ReadData = 32'd0;
      endcase
    end
  end

  assign Irq     = flag_q & irq_en;
  assign GpioOut = out_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: register reads go through an expected-value queue.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_CNT  = BASE + 32'h04;
  localparam logic [31:0] A_CMP  = BASE + 32'h08;
  localparam logic [31:0] A_STAT = BASE + 32'h0C;
  localparam logic [31:0] A_OUT  = BASE + 32'h10;
  localparam logic [31:0] A_UNU  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic        Irq;
  logic [31:0] GpioOut;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  mmio_timer #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit), .Irq(Irq), .GpioOut(GpioOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives the write, which commits at the next posedge.
  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = dat;
    @(negedge clk);
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    exp_t e;
    MemWrite = 1'b0;
    DataAdr  = adr;
    sb.push_back('{tag, exp});
    #1;
    e = sb.pop_front();
    chk(e.tag, ReadData, e.exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = A_CNT; WriteData = '0;
    #1;
    chk("rst_hit", {31'd0, Hit}, 32'd1);
    rd(A_CNT, 32'd0, "rst_count");
    rd(A_CTRL, 32'd0, "rst_ctrl");
    chk("rst_gpio", GpioOut, 32'd0);
    chk("rst_irq", {31'd0, Irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // OUT register
    wr(A_OUT, 32'hDEAD_BEEF);
    chk("out_gpio", GpioOut, 32'hDEAD_BEEF);
    rd(A_OUT, 32'hDEAD_BEEF, "out_rd");
    chk("out_hit", {31'd0, Hit}, 32'd1);
    rd(A_UNU, 32'd0, "unused_rd");
    @(negedge clk);

    // Reset mid-count
    wr(A_CMP, 32'd100);
    wr(A_CTRL, 32'h5);
    repeat (10) @(negedge clk);
    rd(A_CNT, 32'd10, "midcnt_count");
    reset = 1'b1;
    rd(A_CNT, 32'd0, "midrst_count");
    chk("midrst_gpio", GpioOut, 32'd0);
    chk("midrst_irq", {31'd0, Irq}, 32'd0);
    rd(A_CTRL, 32'd0, "midrst_ctrl");
    reset = 1'b0;
    @(negedge clk);
    rd(A_CNT, 32'd0, "postrst_hold");
    @(negedge clk);

    // Auto-reload, period COMPARE+1
    wr(A_CMP, 32'd4);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i < 12; i++) begin
      rd(A_CNT, 32'(i % 5), $sformatf("ar_count%0d", i));
      rd(A_STAT, (i >= 5) ? 32'd1 : 32'd0, $sformatf("ar_flag%0d", i));
      chk($sformatf("ar_irq%0d", i), {31'd0, Irq}, (i >= 5) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    // W1C coincident with match keeps flag; W1C off-match clears it
    repeat (2) @(negedge clk);
    rd(A_CNT, 32'd4, "w1c_pre_count");
    wr(A_STAT, 32'd1);
    rd(A_STAT, 32'd1, "w1c_match_flag");
    chk("w1c_match_irq", {31'd0, Irq}, 32'd1);
    rd(A_CNT, 32'd0, "w1c_match_count");
    wr(A_STAT, 32'd1);
    rd(A_STAT, 32'd0, "w1c_clr_flag");
    chk("w1c_clr_irq", {31'd0, Irq}, 32'd0);
    rd(A_CNT, 32'd1, "w1c_clr_count");

    // Wrap and CPU-write priority
    wr(A_CTRL, 32'h1);
    wr(A_CMP, 32'd5);
    wr(A_CNT, 32'hFFFF_FFFF);
    rd(A_CNT, 32'hFFFF_FFFF, "wrap_load");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd(A_CNT, 32'(i), $sformatf("wrap_count%0d", i));
    end
    @(negedge clk);
    wr(A_CNT, 32'h10);
    rd(A_CNT, 32'h10, "wrprio_count");
    rd(A_STAT, 32'd0, "wrprio_flag");
    wr(A_CTRL, 32'h0);
    rd(A_CNT, 32'h11, "dis_count");
    @(negedge clk);
    rd(A_CNT, 32'h11, "dis_hold");

    // Out-of-window accesses
    wr(A_OUT, 32'h0000_A5A5);
    MemWrite = 1'b1; DataAdr = BASE + 32'h20; WriteData = 32'h1234;
    #1;
    chk("oow_hi_hit", {31'd0, Hit}, 32'd0);
    chk("oow_hi_rd", ReadData, 32'd0);
    @(negedge clk);
    DataAdr = BASE - 32'd4; WriteData = 32'h1234;
    #1;
    chk("oow_lo_hit", {31'd0, Hit}, 32'd0);
    chk("oow_lo_rd", ReadData, 32'd0);
    @(negedge clk);
    MemWrite = 1'b0;
    wr(A_UNU, 32'h1234);
    rd(A_UNU, 32'd0, "unused_wr");
    rd(A_CTRL, 32'd0, "oow_ctrl");
    rd(A_CNT, 32'h11, "oow_count");
    rd(A_CMP, 32'd5, "oow_cmp");
    rd(A_OUT, 32'h0000_A5A5, "oow_out");
    chk("oow_gpio", GpioOut, 32'h0000_A5A5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
